load_writeback: RTL and testbench

- Writer-side counterpart to the CPU register file.
- Takes a completed instruction result and drives the register-file write port (write, write_addr, data_in).
- For ALU results, it writes the value directly.
- For loads, it issues one word read on the data memory bus, waits out waitrequest, then extracts, extends or merges the bytes before writing.
- Sits between execute and the register file in the multicycle CPU.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/load_writeback_if.sv | 27 ++
 rtl/load_writeback_align.sv | 51 +++++
 rtl/load_writeback.sv | 121 ++++++++++++
 tb/tb_load_writeback.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the load/writeback path.
//
// Contents:
//   WORD_W, REG_ADDR_W  - datapath and register-address widths
//   load_op_t           - kind of writeback requested by execute
//   wb_state_t          - load_writeback sequencer states
//   align_fault()       - true when a load op/byte-offset pair must fault
//
// Configuration macro: LOAD_WRITEBACK_LWLR_EN enables the unaligned
// LWL/LWR loads; without it those ops always fault.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LB   = 3'd1,
    OP_LBU  = 3'd2,
    OP_LH   = 3'd3,
    OP_LHU  = 3'd4,
    OP_LW   = 3'd5,
    OP_LWL  = 3'd6,
    OP_LWR  = 3'd7
  } load_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    WRITE   = 2'd2,
    FAULT   = 2'd3
  } wb_state_t;

  // Halfwords need an even address, words a multiple of four.
  function automatic logic align_fault(load_op_t op, logic [1:0] k);
    logic f;
    f = 1'b0;
    case (op)
      OP_LH, OP_LHU: f = k[0];
      OP_LW:         f = (k != 2'b00);
`ifndef LOAD_WRITEBACK_LWLR_EN
      OP_LWL, OP_LWR: f = 1'b1;
`endif
      default:       f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Data-memory read bus between load_writeback (master) and memory (slave).
//
// Signals:
//   mem_read        master -> slave  read strobe, held until accepted
//   mem_address     master -> slave  word-aligned byte address
//   mem_byteenable  master -> slave  all lanes while reading, else 0
//   mem_waitrequest slave -> master  stall; read completes on an edge where 0
//   mem_readdata    slave -> master  little-endian word
interface load_writeback_if;
  import mips_pkg::*;

  logic              mem_read;
  logic [WORD_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_waitrequest;
  logic [WORD_W-1:0] mem_readdata;

  modport master (
    output mem_read, mem_address, mem_byteenable,
    input  mem_waitrequest, mem_readdata
  );

  modport slave (
    input  mem_read, mem_address, mem_byteenable,
    output mem_waitrequest, mem_readdata
  );
endinterface

// File: rtl/load_writeback_align.sv
// load_align: combinational byte extraction / extension / merge for loads.
//
// Ports:
//   op           load kind
//   k            byte offset within the word (addr[1:0])
//   mem_readdata word returned by the bus, little-endian lanes
//   rt_old       current destination value, merged by LWL/LWR
//   result       value to write to the register file
//
// Configuration macro: LOAD_WRITEBACK_LWLR_EN adds the LWL/LWR merge.
module load_align
  import mips_pkg::*;
(
  input  load_op_t          op,
  input  logic [1:0]        k,
  input  logic [WORD_W-1:0] mem_readdata,
  input  logic [WORD_W-1:0] rt_old,
  output logic [WORD_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword offsets are only 0 or 2 here; odd ones fault upstream.
  assign byte_sel = mem_readdata[{k, 3'b000} +: 8];
  assign half_sel = mem_readdata[{k[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = '0;
    case (op)
      OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: result = {24'h0, byte_sel};
      OP_LH:  result = {{16{half_sel[15]}}, half_sel};
      OP_LHU: result = {16'h0, half_sel};
      OP_LW:  result = mem_readdata;
`ifdef LOAD_WRITEBACK_LWLR_EN
      // 3-k equals ~k for a two-bit offset.
      OP_LWL: result = (mem_readdata << {~k, 3'b000})
                     | (rt_old & (32'h00FF_FFFF >> {k, 3'b000}));
      OP_LWR: result = (mem_readdata >> {k, 3'b000})
                     | (rt_old & ~(32'hFFFF_FFFF >> {k, 3'b000}));
`else
      // These ops fault before reaching the bus; the value is never written.
      OP_LWL, OP_LWR: result = rt_old;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// load_writeback: drives the register-file write port from either an ALU
// result (written next cycle) or a data-memory load (one word read, then
// extract / extend / merge via load_align).
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   start, op, addr,       request, sampled only when idle
//   alu_result, rt_old, dest
//   mem                    data-memory read bus (master side)
//   busy                   high whenever not idle
//   reg_write, reg_write_addr, reg_data   register-file write port
//   done                   one-cycle completion pulse
//   load_error             one-cycle pulse with done on a faulting request
//
// Configuration macro: LOAD_WRITEBACK_LWLR_EN enables LWL/LWR.
module load_writeback
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  load_op_t              op,
  input  logic [WORD_W-1:0]     addr,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic [WORD_W-1:0]     rt_old,
  input  logic [REG_ADDR_W-1:0] dest,
  load_writeback_if.master      mem,
  output logic                  busy,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] reg_write_addr,
  output logic [WORD_W-1:0]     reg_data,
  output logic                  done,
  output logic                  load_error
);

  wb_state_t             state;
  load_op_t              op_q;
  logic [1:0]            k_q;
  logic [WORD_W-1:0]     rt_old_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [WORD_W-1:0]     load_result;

  load_align u_align (
    .op           (op_q),
    .k            (k_q),
    .mem_readdata (mem.mem_readdata),
    .rt_old       (rt_old_q),
    .result       (load_result)
  );

  // All outputs are registered: they are set on the edge that enters the
  // state they belong to, so WRITE/FAULT pulses appear exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      op_q               <= OP_NONE;
      k_q                <= '0;
      rt_old_q           <= '0;
      dest_q             <= '0;
      mem.mem_read       <= 1'b0;
      mem.mem_address    <= '0;
      mem.mem_byteenable <= '0;
      busy               <= 1'b0;
      reg_write          <= 1'b0;
      reg_write_addr     <= '0;
      reg_data           <= '0;
      done               <= 1'b0;
      load_error         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values regardless of statement order.
      done       <= 1'b0;
      load_error <= 1'b0;
      reg_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            k_q      <= addr[1:0];
            rt_old_q <= rt_old;
            dest_q   <= dest;
            busy     <= 1'b1;
            if (op == OP_NONE) begin
              state          <= WRITE;
              done           <= 1'b1;
              reg_write      <= (dest != '0);
              reg_write_addr <= dest;
              reg_data       <= alu_result;
            end else if (align_fault(op, addr[1:0])) begin
              state      <= FAULT;
              done       <= 1'b1;
              load_error <= 1'b1;
            end else begin
              state              <= MEM_REQ;
              mem.mem_read       <= 1'b1;
              mem.mem_address    <= {addr[WORD_W-1:2], 2'b00};
              mem.mem_byteenable <= 4'b1111;
            end
          end
        end
        MEM_REQ: begin
          if (!mem.mem_waitrequest) begin
            state              <= WRITE;
            mem.mem_read       <= 1'b0;
            mem.mem_byteenable <= '0;
            done               <= 1'b1;
            reg_write          <= (dest_q != '0);
            reg_write_addr     <= dest_q;
            reg_data           <= load_result;
          end
        end
        WRITE, FAULT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// Self-checking bench for load_writeback. Honours LOAD_WRITEBACK_LWLR_EN.
module tb_load_writeback;
  import mips_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  start;
  load_op_t              op;
  logic [WORD_W-1:0]     addr, alu_result, rt_old;
  logic [REG_ADDR_W-1:0] dest;
  logic                  busy, reg_write, done, load_error;
  logic [REG_ADDR_W-1:0] reg_write_addr;
  logic [WORD_W-1:0]     reg_data;

  load_writeback_if bus ();

  load_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .op             (op),
    .addr           (addr),
    .alu_result     (alu_result),
    .rt_old         (rt_old),
    .dest           (dest),
    .mem            (bus),
    .busy           (busy),
    .reg_write      (reg_write),
    .reg_write_addr (reg_write_addr),
    .reg_data       (reg_data),
    .done           (done),
    .load_error     (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_maddr = '0;
  logic [31:0] last_data = '0;

  // Byte-lane view of a load: which memory byte lands in which result byte.
  function automatic void model(input load_op_t o, input logic [31:0] a,
                                input logic [31:0] m, input logic [31:0] rt,
                                output logic [31:0] res, output logic flt);
    logic [7:0] b [4];
    logic [7:0] r [4];
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      b[i] = m[8*i +: 8];
      r[i] = rt[8*i +: 8];
    end
    res = 32'h0;
    flt = 1'b0;
    case (o)
      OP_LB, OP_LBU: begin
        res = {24'h0, b[k]};
        if (o == OP_LB && b[k] >= 8'h80) res = res + 32'hFFFF_FF00;
      end
      OP_LH, OP_LHU: begin
        if (k % 2 != 0) flt = 1'b1;
        else begin
          res = {16'h0, b[k+1], b[k]};
          if (o == OP_LH && b[k+1] >= 8'h80) res = res + 32'hFFFF_0000;
        end
      end
      OP_LW: begin
        if (k != 0) flt = 1'b1;
        else res = m;
      end
      OP_LWL, OP_LWR: begin
`ifdef LOAD_WRITEBACK_LWLR_EN
        for (int i = 0; i < 4; i++) begin
          if (o == OP_LWL && i >= 3 - k) r[i] = b[i - (3 - k)];
          if (o == OP_LWR && i <= 3 - k) r[i] = b[i + k];
        end
        res = {r[3], r[2], r[1], r[0]};
`else
        flt = 1'b1;
`endif
      end
      default: res = 32'h0;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("byteenable", {28'h0, bus.mem_byteenable}, bus.mem_read ? 32'hF : 32'h0);
      if (bus.mem_read) check("mem_address", bus.mem_address, exp_maddr);
      if (!done) begin
        check("we_outside_done", {31'h0, reg_write}, 32'h0);
        check("err_outside_done", {31'h0, load_error}, 32'h0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_done", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("load_error", {31'h0, load_error}, {31'h0, e.err});
        check("reg_write", {31'h0, reg_write}, {31'h0, e.we});
        if (!e.err) begin
          check("reg_write_addr", {27'h0, reg_write_addr}, {27'h0, e.waddr});
          check("reg_data", reg_data, e.data);
          last_data = e.data;
        end else begin
          check("reg_data_hold", reg_data, last_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Issues one request at a negedge and returns at the negedge after done.
  task automatic do_txn(input load_op_t o, input logic [31:0] a, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [4:0] d, input logic [31:0] rdata,
                        input int stalls, input bit poke,
                        output logic [31:0] got_data, output logic got_we,
                        output logic got_err, output int lat);
    logic [31:0] res;
    logic        flt;
    exp_t        e;
    int          rd_cycles, stall_cnt, exp_lat, exp_rd;
    bit          seen;
    if (o == OP_NONE) begin res = alu; flt = 1'b0; end
    else model(o, a, rdata, rt, res, flt);
    e.we = !flt && (d != 5'd0);
    e.waddr = d;
    e.data = res;
    e.err = flt;
    exp_q.push_back(e);
    exp_maddr = {a[31:2], 2'b00};
    exp_lat = (flt || o == OP_NONE) ? 1 : 2 + stalls;
    exp_rd  = (flt || o == OP_NONE) ? 0 : 1 + stalls;

    op = o; addr = a; alu_result = alu; rt_old = rt; dest = d;
    bus.mem_readdata = rdata;
    bus.mem_waitrequest = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_cycles = 0; stall_cnt = 0; seen = 0; lat = 0;
    got_data = '0; got_we = 1'b0; got_err = 1'b0;
    for (int cyc = 1; cyc <= 50 && !seen; cyc++) begin
      if (poke && cyc == 1) begin
        start = 1'b1; op = OP_NONE; dest = 5'd7; alu_result = 32'h1111_1111; rt_old = 32'h0;
      end
      if (poke && cyc == 2) start = 1'b0;
      if (bus.mem_read) rd_cycles++;
      bus.mem_waitrequest = bus.mem_read && (stall_cnt < stalls);
      if (bus.mem_waitrequest) stall_cnt++;
      if (done) begin
        seen = 1;
        lat = cyc;
        got_data = reg_data;
        got_we = reg_write;
        got_err = load_error;
        check("busy_at_done", {31'h0, busy}, 32'h1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    bus.mem_waitrequest = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'h0, 32'h1);
      exp_q.delete();
    end else begin
      check("latency", lat, exp_lat);
      check("mem_read_cycles", rd_cycles, exp_rd);
      check("idle_after_done", {31'h0, busy}, 32'h0);
    end
  endtask

  logic [31:0] gd;
  logic        gw, ge;
  int          gl;

  initial begin
    reset = 1'b0; start = 1'b0; op = OP_NONE; addr = '0; alu_result = '0;
    rt_old = '0; dest = '0;
    bus.mem_waitrequest = 1'b0; bus.mem_readdata = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_byteenable", {28'h0, bus.mem_byteenable}, 32'h0);
    check("rst_busy_done_err_we", {28'h0, busy, done, load_error, reg_write}, 32'h0);
    check("rst_reg_write_addr", {27'h0, reg_write_addr}, 32'h0);
    check("rst_reg_data", reg_data, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ALU result: write in cycle 1, no bus traffic.
    do_txn(OP_NONE, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd5, 32'h0, 0, 0, gd, gw, ge, gl);
    check("none_data", gd, 32'hDEAD_BEEF);
    check("none_we", {31'h0, gw}, 32'h1);
    check("none_lat", gl, 1);

    // LB from byte 3 with three stall cycles.
    do_txn(OP_LB, 32'h1003, 32'h0, 32'h0, 5'd3, 32'h8012_3456, 3, 0, gd, gw, ge, gl);
    check("lb_data", gd, 32'hFFFF_FF80);
    check("lb_lat", gl, 5);

    // LHU into r0: done without a write.
    do_txn(OP_LHU, 32'h2002, 32'h0, 32'h0, 5'd0, 32'hABCD_0000, 0, 0, gd, gw, ge, gl);
    check("lhu_r0_we", {31'h0, gw}, 32'h0);
    check("lhu_r0_data", gd, 32'h0000_ABCD);

    // Misaligned LH faults.
    do_txn(OP_LH, 32'h2001, 32'h0, 32'h0, 5'd4, 32'h0, 0, 0, gd, gw, ge, gl);
    check("lh_fault_err", {31'h0, ge}, 32'h1);

    // Unaligned merges.
    do_txn(OP_LWL, 32'h3001, 32'h0, 32'hAABB_CCDD, 5'd6, 32'h4433_2211, 0, 0, gd, gw, ge, gl);
`ifdef LOAD_WRITEBACK_LWLR_EN
    check("lwl_data", gd, 32'h2211_CCDD);
`else
    check("lwl_fault", {31'h0, ge}, 32'h1);
`endif
    do_txn(OP_LWR, 32'h3002, 32'h0, 32'hAABB_CCDD, 5'd6, 32'h4433_2211, 1, 0, gd, gw, ge, gl);
`ifdef LOAD_WRITEBACK_LWLR_EN
    check("lwr_data", gd, 32'hAABB_4433);
`else
    check("lwr_fault", {31'h0, ge}, 32'h1);
`endif

    // Further extraction corners.
    do_txn(OP_LH, 32'h0002, 32'h0, 32'h0, 5'd8, 32'h8001_7FFF, 0, 0, gd, gw, ge, gl);
    check("lh_hi_data", gd, 32'hFFFF_8001);
    do_txn(OP_LH, 32'h0000, 32'h0, 32'h0, 5'd8, 32'h1234_F00D, 1, 0, gd, gw, ge, gl);
    check("lh_lo_data", gd, 32'hFFFF_F00D);
    do_txn(OP_LBU, 32'h0001, 32'h0, 32'h0, 5'd10, 32'h0000_C300, 0, 0, gd, gw, ge, gl);
    check("lbu_data", gd, 32'h0000_00C3);
    do_txn(OP_LB, 32'h0000, 32'h0, 32'h0, 5'd11, 32'hFFFF_FF7F, 0, 0, gd, gw, ge, gl);
    check("lb_pos_data", gd, 32'h0000_007F);
    do_txn(OP_LW, 32'h0006, 32'h0, 32'h0, 5'd12, 32'h0, 0, 0, gd, gw, ge, gl);
    check("lw_fault_err", {31'h0, ge}, 32'h1);

    // start while busy is ignored.
    do_txn(OP_LW, 32'h0040, 32'h0, 32'h0, 5'd9, 32'h1234_5678, 2, 1, gd, gw, ge, gl);
    check("poke_data", gd, 32'h1234_5678);

    // Reset between edges during MEM_REQ.
    op = OP_LW; addr = 32'h3000; dest = 5'd13; exp_maddr = 32'h3000;
    bus.mem_waitrequest = 1'b1; bus.mem_readdata = 32'hCAFE_F00D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_mem_read", {31'h0, bus.mem_read}, 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_mem_read", {31'h0, bus.mem_read}, 32'h0);
    check("mid_reset_busy_we_done", {29'h0, busy, reg_write, done}, 32'h0);
    check("mid_reset_reg_data", reg_data, 32'h0);
    last_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_waitrequest = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {31'h0, busy}, 32'h0);

    do_txn(OP_LW, 32'h0080, 32'h0, 32'h0, 5'd14, 32'h0BAD_CAFE, 0, 0, gd, gw, ge, gl);
    check("post_reset_lw", gd, 32'h0BAD_CAFE);
    check("post_reset_lat", gl, 2);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
